// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, funct3
// values, FSM state codes and datapath mux / ALU / immediate selects.
package mc_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned STATE_W  = 4;

  // Major opcodes handled by the controller
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

  // funct3 values with a defined ALU meaning
  localparam logic [FUNCT3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_SLT     = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_OR      = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_AND     = 3'b111;
  localparam logic [FUNCT3_W-1:0] F3_BEQ     = 3'b000;

  // FSM states; encodings not listed fall back to FETCH
  typedef enum logic [STATE_W-1:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BEQ       = 4'd9,
    S_JAL       = 4'd10,
    S_ILLEGAL   = 4'd11
  } state_e;

  // ALU operation class requested by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: maps the FSM's ALU op class plus funct fields to an
// ALU control code, and flags funct3 values the controller does not support.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       func7_bit5,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  logic [2:0] funct_ctrl;

  // funct3 decode; SUB only for R-type with instr[30] set (ADDI ignores it)
  always_comb begin
    funct_ctrl = ALU_ADD;
    bad_funct  = 1'b0;
    case (funct3)
      F3_ADD_SUB: funct_ctrl = (is_rtype && func7_bit5) ? ALU_SUB : ALU_ADD;
      F3_SLT:     funct_ctrl = ALU_SLT;
      F3_OR:      funct_ctrl = ALU_OR;
      F3_AND:     funct_ctrl = ALU_AND;
      default:    bad_funct  = 1'b1;
    endcase
  end

  // Select between fixed ADD/SUB and the funct-derived operation
  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctrl;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/
// writeback for R, I-ALU, LW, SW and BEQ with a memory ready handshake and
// illegal-instruction detection. Optional JAL support: define MC_CTRL_JAL_EN.
// Outputs decode the registered state; the enables are additionally
// qualified by mem_ready/zero and forced low while reset is asserted so a
// reset aborts an in-flight access in the same cycle.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W   = 3,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  func7_bit5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  pcwrite,
  output logic                  adrsource,
  output logic                  memwrite,
  output logic                  irwrite,
  output logic                  regwrite,
  output logic [1:0]            imm_source,
  output logic [1:0]            alu_source_a,
  output logic [1:0]            alu_source_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            resultsource,
  output logic                  illegal_instr
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic [2:0] alu_ctrl3;
  logic       bad_funct;
  logic       is_rtype;

  assign is_rtype = (opcode == OP_RTYPE);

  mc_alu_decoder u_alu_dec (
    .aluop       (aluop),
    .funct3      (funct3),
    .func7_bit5  (func7_bit5),
    .is_rtype    (is_rtype),
    .alu_control (alu_ctrl3),
    .bad_funct   (bad_funct)
  );

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:           state_d = bad_funct ? S_ILLEGAL : S_EXEC_R;
          OP_ITYPE:           state_d = bad_funct ? S_ILLEGAL : S_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADR;
          OP_BRANCH:          state_d = (funct3 == F3_BEQ) ? S_BEQ : S_ILLEGAL;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:             state_d = S_JAL;
`endif
          default:            state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR:   state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BEQ:       state_d = S_FETCH;
`ifdef MC_CTRL_JAL_EN
      S_JAL:       state_d = S_ALU_WB;
`endif
      S_ILLEGAL:   state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Per-state datapath controls; enables gated off during reset
  always_comb begin
    mem_req       = 1'b0;
    pcwrite       = 1'b0;
    adrsource     = 1'b0;
    memwrite      = 1'b0;
    irwrite       = 1'b0;
    regwrite      = 1'b0;
    imm_source    = IMM_I;
    alu_source_a  = SRCA_PC;
    alu_source_b  = SRCB_RD2;
    resultsource  = RES_ALUOUT;
    illegal_instr = 1'b0;
    aluop         = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_source_a = SRCA_PC;
        alu_source_b = SRCB_FOUR;
        resultsource = RES_ALURESULT;
        irwrite      = mem_ready;
        pcwrite      = mem_ready;
      end
      S_DECODE: begin
        alu_source_a = SRCA_OLDPC;
        alu_source_b = SRCB_IMM;
        imm_source   = IMM_B;
`ifdef MC_CTRL_JAL_EN
        if (opcode == OP_JAL) imm_source = IMM_J;
`endif
      end
      S_MEM_ADR: begin
        alu_source_a = SRCA_RD1;
        alu_source_b = SRCB_IMM;
        imm_source   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_READ: begin
        mem_req   = 1'b1;
        adrsource = 1'b1;
      end
      S_MEM_WB: begin
        resultsource = RES_READDATA;
        regwrite     = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        adrsource = 1'b1;
        memwrite  = 1'b1;
      end
      S_EXEC_R: begin
        alu_source_a = SRCA_RD1;
        alu_source_b = SRCB_RD2;
        aluop        = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        alu_source_a = SRCA_RD1;
        alu_source_b = SRCB_IMM;
        imm_source   = IMM_I;
        aluop        = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        resultsource = RES_ALUOUT;
        regwrite     = 1'b1;
      end
      S_BEQ: begin
        alu_source_a = SRCA_RD1;
        alu_source_b = SRCB_RD2;
        aluop        = ALUOP_SUB;
        resultsource = RES_ALUOUT;
        pcwrite      = zero;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        alu_source_a = SRCA_OLDPC;
        alu_source_b = SRCB_FOUR;
        imm_source   = IMM_J;
        resultsource = RES_ALUOUT;
        pcwrite      = 1'b1;
      end
`endif
      S_ILLEGAL:   illegal_instr = 1'b1;
      default: ;
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_ctrl3);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm (default build: JAL disabled, ILLEGAL_HALT=1).
// Expected outputs come from a per-instruction micro-step model; a negedge
// process compares every cycle, and literal counts pin latencies/pulses.
module tb_mc_ctrl_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       pcwrite;
    logic       adrsource;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] imm;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] res;
    logic       ill;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       func7_bit5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, pcwrite, adrsource, memwrite, irwrite, regwrite, illegal_instr;
  logic [1:0] imm_source, alu_source_a, alu_source_b, resultsource;
  logic [2:0] alu_control;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALU_CTRL_W(3), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .func7_bit5(func7_bit5), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .pcwrite(pcwrite), .adrsource(adrsource),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .imm_source(imm_source), .alu_source_a(alu_source_a),
    .alu_source_b(alu_source_b), .alu_control(alu_control),
    .resultsource(resultsource), .illegal_instr(illegal_instr)
  );

  outs_t act, exp_o;
  assign act = {mem_req, pcwrite, adrsource, memwrite, irwrite, regwrite,
                imm_source, alu_source_a, alu_source_b, alu_control,
                resultsource, illegal_instr};

  int    checks = 0, failures = 0;
  bit    chk_en = 1'b0;
  string step = "none";
  int    cyc_n = 0, n_regwrite = 0, n_memwrite = 0, n_rdreq = 0, n_pcwrite = 0, n_illegal = 0;
  int    last_ir = 0, last_rw = 0, last_pc = 0;
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_f7 = 1'b0;
  logic       cur_z = 1'b0;

  // ---------------- model: outputs per micro-step ----------------
  function automatic outs_t o_base();
    outs_t o;
    o = '0;
    o.alu = 3'b010;
    return o;
  endfunction
  function automatic outs_t o_fetch(input logic rdy);
    outs_t o;
    o = o_base();
    o.mem_req = 1'b1; o.srca = 2'b00; o.srcb = 2'b10; o.res = 2'b10;
    o.irwrite = rdy; o.pcwrite = rdy;
    return o;
  endfunction
  function automatic outs_t o_decode();
    outs_t o;
    o = o_base();
    o.srca = 2'b01; o.srcb = 2'b01; o.imm = 2'b10;
    return o;
  endfunction
  function automatic outs_t o_memadr(input logic store);
    outs_t o;
    o = o_base();
    o.srca = 2'b10; o.srcb = 2'b01; o.imm = store ? 2'b01 : 2'b00;
    return o;
  endfunction
  function automatic outs_t o_memread();
    outs_t o;
    o = o_base();
    o.mem_req = 1'b1; o.adrsource = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwb();
    outs_t o;
    o = o_base();
    o.res = 2'b01; o.regwrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_memwrite();
    outs_t o;
    o = o_memread();
    o.memwrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_exec(input logic isr, input logic [2:0] aluc);
    outs_t o;
    o = o_base();
    o.srca = 2'b10; o.srcb = isr ? 2'b00 : 2'b01; o.alu = aluc;
    return o;
  endfunction
  function automatic outs_t o_aluwb();
    outs_t o;
    o = o_base();
    o.regwrite = 1'b1;
    return o;
  endfunction
  function automatic outs_t o_beq(input logic z);
    outs_t o;
    o = o_base();
    o.srca = 2'b10; o.srcb = 2'b00; o.alu = 3'b110; o.pcwrite = z;
    return o;
  endfunction
  function automatic outs_t o_illegal();
    outs_t o;
    o = o_base();
    o.ill = 1'b1;
    return o;
  endfunction
  function automatic outs_t rst_mask(input outs_t o_in);
    outs_t o;
    o = o_in;
    o.mem_req = 1'b0; o.pcwrite = 1'b0; o.memwrite = 1'b0;
    o.irwrite = 1'b0; o.regwrite = 1'b0;
    return o;
  endfunction
  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic isr);
    case (f3)
      3'd0:    return (isr && f7) ? 3'b110 : 3'b010;
      3'd2:    return 3'b111;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  // Compare every cycle and count output pulses
  always @(negedge clk) begin
    cyc_n++;
    if (chk_en) begin
      checks++;
      if (act !== exp_o) begin
        failures++;
        $display("FAIL cycle %0d step %s: got %h required %h", cyc_n, step, act, exp_o);
      end
    end
    if (regwrite === 1'b1) begin n_regwrite++; last_rw = cyc_n; end
    if (memwrite === 1'b1) n_memwrite++;
    if (mem_req === 1'b1 && adrsource === 1'b1) n_rdreq++;
    if (pcwrite === 1'b1) begin n_pcwrite++; last_pc = cyc_n; end
    if (irwrite === 1'b1) last_ir = cyc_n;
    if (illegal_instr === 1'b1) n_illegal++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input outs_t e, input string nm, input logic rdy, input logic rst);
    @(posedge clk); #1;
    opcode = cur_op; funct3 = cur_f3; func7_bit5 = cur_f7; zero = cur_z;
    mem_ready = rdy; reset = rst; exp_o = e; step = nm; chk_en = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // One instruction: fw fetch wait cycles, w memory wait cycles
  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input int fw, input int w);
    bit is_r, is_i, good;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    is_r = (op == 7'b0110011);
    is_i = (op == 7'b0010011);
    good = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
    for (int k = 0; k < fw; k++) cyc(o_fetch(1'b0), "fetch_wait", 1'b0, 1'b0);
    cyc(o_fetch(1'b1), "fetch", 1'b1, 1'b0);
    cyc(o_decode(), "decode", 1'b1, 1'b0);
    if ((is_r || is_i) && good) begin
      cyc(o_exec(is_r, alu_of(f3, f7, is_r)), "exec", 1'b1, 1'b0);
      cyc(o_aluwb(), "alu_wb", 1'b1, 1'b0);
    end else if (op == 7'b0000011) begin
      cyc(o_memadr(1'b0), "mem_adr_lw", 1'b1, 1'b0);
      for (int k = 0; k < w; k++) cyc(o_memread(), "mem_read_wait", 1'b0, 1'b0);
      cyc(o_memread(), "mem_read", 1'b1, 1'b0);
      cyc(o_memwb(), "mem_wb", 1'b1, 1'b0);
    end else if (op == 7'b0100011) begin
      cyc(o_memadr(1'b1), "mem_adr_sw", 1'b1, 1'b0);
      for (int k = 0; k < w; k++) cyc(o_memwrite(), "mem_write_wait", 1'b0, 1'b0);
      cyc(o_memwrite(), "mem_write", 1'b1, 1'b0);
    end else if (op == 7'b1100011 && f3 == 3'd0) begin
      cyc(o_beq(z), "beq", 1'b1, 1'b0);
    end else begin
      for (int k = 0; k < 3; k++) cyc(o_illegal(), "illegal", 1'b1, 1'b0);
      cyc(rst_mask(o_illegal()), "illegal_reset", 1'b1, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    // Reset holds FETCH with all enables forced off, even with mem_ready high
    cyc(rst_mask(o_fetch(1'b0)), "reset", 1'b0, 1'b1);
    cyc(rst_mask(o_fetch(1'b1)), "reset_rdy", 1'b1, 1'b1);

    // ADD x3,x1,x2: 4 cycles, single regwrite
    s = n_regwrite;
    run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    settle();
    chk("add_regwrite_pulses", n_regwrite - s, 1);
    chk("add_latency", last_rw - last_ir, 3);

    run(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);   // SUB
    run(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);   // ADDI, instr[30] ignored
    run(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);   // SLT
    run(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0);   // ORI
    run(7'b0110011, 3'b111, 1'b0, 1'b0, 1, 0);   // AND, one fetch wait
    run(7'b0010011, 3'b111, 1'b0, 1'b0, 2, 0);   // ANDI, two fetch waits

    // LW with mem_ready low 3 cycles in MEM_READ
    s = n_rdreq;
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
    settle();
    chk("lw_read_req_cycles", n_rdreq - s, 4);
    chk("lw_latency", last_rw - last_ir, 7);

    // LW zero-wait: 5 cycles
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);
    settle();
    chk("lw0_latency", last_rw - last_ir, 4);

    // SW with mem_ready delayed 2 cycles
    s = n_memwrite;
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 2);
    settle();
    chk("sw_memwrite_cycles", n_memwrite - s, 3);

    // BEQ taken / not taken
    s = n_pcwrite;
    run(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    settle();
    chk("beq_taken_pcwrites", n_pcwrite - s, 2);
    chk("beq_taken_latency", last_pc - last_ir, 2);
    s = n_pcwrite;
    run(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
    settle();
    chk("beq_not_taken_pcwrites", n_pcwrite - s, 1);

    // Reset during MEM_WRITE aborts the store in the same cycle
    s = n_memwrite;
    cur_op = 7'b0100011; cur_f3 = 3'b010; cur_f7 = 1'b0; cur_z = 1'b0;
    cyc(o_fetch(1'b1), "abort_fetch", 1'b1, 1'b0);
    cyc(o_decode(), "abort_decode", 1'b1, 1'b0);
    cyc(o_memadr(1'b1), "abort_mem_adr", 1'b1, 1'b0);
    cyc(o_memwrite(), "abort_mem_write", 1'b0, 1'b0);
    cyc(rst_mask(o_memwrite()), "abort_reset", 1'b0, 1'b1);
    cyc(o_fetch(1'b0), "abort_refetch", 1'b0, 1'b0);
    settle();
    chk("abort_memwrite_cycles", n_memwrite - s, 1);

    // Illegal encodings: sticky until reset
    s = n_illegal;
    run(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
    settle();
    chk("illegal_opcode_cycles", n_illegal - s, 4);
    run(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);   // JAL without the option
    run(7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0);   // R-type funct3 001
    run(7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0);   // I-type funct3 100
    run(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);   // BNE
    // Recovery after trap
    s = n_regwrite;
    run(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    settle();
    chk("post_trap_regwrite", n_regwrite - s, 1);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
